// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with synchronous load and a wrap pulse.
// Define GRAY_CNT_CHECK_EN to build the sticky one-bit-change checker that drives err.
module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] bin_reg;
   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] gray_reg;
   logic [WIDTH-1:0] gray_next;
   logic             wrap_reg;
   logic             wrap_next;
   logic             step_next;

   always_comb begin
      bin_next  = bin_reg;
      wrap_next = 1'b0;
      step_next = 1'b0;
      if (load) begin
         bin_next = load_val;
      end else if (en) begin
         step_next = 1'b1;
         if (up) begin
            bin_next  = bin_reg + ONE;
            wrap_next = &bin_reg;
         end else begin
            bin_next  = bin_reg - ONE;
            wrap_next = ~|bin_reg;
         end
      end
      gray_next = bin_next ^ (bin_next >> 1);
   end

   // gray is its own register so the output never carries a combinational path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_reg  <= '0;
         gray_reg <= '0;
         wrap_reg <= 1'b0;
      end else begin
         bin_reg  <= bin_next;
         gray_reg <= gray_next;
         wrap_reg <= wrap_next;
      end
   end

   assign bin  = bin_reg;
   assign gray = gray_reg;
   assign wrap = wrap_reg;

`ifdef GRAY_CNT_CHECK_EN
   logic [WIDTH-1:0] gray_prev_reg;
   logic             stepped_reg;
   logic             err_reg;

   // The last update is judged one edge later, once both old and new gray are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gray_prev_reg <= '0;
         stepped_reg   <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         gray_prev_reg <= gray_reg;
         stepped_reg   <= step_next;
         if (stepped_reg && ($countones(gray_reg ^ gray_prev_reg) != 1)) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: stimulus pushes expected results, a monitor pops and compares.
module tb_gray_counter;
   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] gray;
   logic [W-1:0] bin;
   logic         wrap;
   logic         err;

   always #5 clk = ~clk;

   gray_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .gray     (gray),
      .bin      (bin),
      .wrap     (wrap),
      .err      (err)
   );

   typedef struct {
      int b;
      int g;
      int pg;
      bit w;
      bit stepped;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   gtab[M];
   int   mcnt;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reflected-binary table built by mirroring: independent of the xor-shift formula.
   task automatic build_gray_table();
      gtab[0] = 0;
      for (int k = 0; k < W; k++) begin
         for (int i = 0; i < (1 << k); i++) begin
            gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | (1 << k);
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         $display("[TB] bin=%0h gray=%0h wrap=%0b err=%0b (exp bin=%0h gray=%0h wrap=%0b)",
                  bin, gray, wrap, err, mon_e.b, mon_e.g, mon_e.w);
         chk("bin", int'(bin), mon_e.b);
         chk("gray", int'(gray), mon_e.g);
         chk("wrap", int'(wrap), int'(mon_e.w));
         chk("err", int'(err), 0);
         if (mon_e.stepped) chk("one_bit_change", $countones(gray ^ mon_e.pg[W-1:0]), 1);
      end
   end

   task automatic step(input bit l, input int lv, input bit e_, input bit u);
      exp_t x;
      @(negedge clk);
      load     = l;
      load_val = lv[W-1:0];
      en       = e_;
      up       = u;
      x.pg      = gtab[mcnt];
      x.w       = 1'b0;
      x.stepped = 1'b0;
      if (l) begin
         mcnt = lv % M;
      end else if (e_) begin
         x.stepped = 1'b1;
         if (u) begin
            x.w  = (mcnt == M - 1);
            mcnt = (mcnt + 1) % M;
         end else begin
            x.w  = (mcnt == 0);
            mcnt = (mcnt + M - 1) % M;
         end
      end
      x.b = mcnt;
      x.g = gtab[mcnt];
      q.push_back(x);
   endtask

   task automatic do_reset();
      @(negedge clk);
      load = 1'b0;
      en   = 1'b0;
      rst  = 1'b1;
      @(negedge clk);
      chk("rst_bin", int'(bin), 0);
      chk("rst_gray", int'(gray), 0);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_err", int'(err), 0);
      rst  = 1'b0;
      mcnt = 0;
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      up       = 1'b0;
      load     = 1'b0;
      load_val = '0;
      mcnt     = 0;
      build_gray_table();
      #1;
      chk("async_rst_bin", int'(bin), 0);
      chk("async_rst_gray", int'(gray), 0);
      do_reset();

      // Full up cycle including the wrap back to 0.
      for (int i = 0; i < M + 1; i++) step(0, 0, 1, 1);

      // Down from reset wraps to max, then three more down steps.
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

      // Load beats en, then count from the loaded value.
      step(1, 'hA, 1, 1);
      step(0, 0, 1, 1);

      // Load max then step up: wrap from the count, not from the load.
      step(1, M - 1, 0, 0);
      step(0, 0, 1, 1);
      step(1, 0, 0, 0);
      step(1, M - 1, 1, 0);
      step(0, 0, 0, 1);

      // Async reset between edges while at bin=5.
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
      @(negedge clk);
      en   = 1'b0;
      load = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_bin", int'(bin), 0);
      chk("mid_rst_gray", int'(gray), 0);
      chk("mid_rst_wrap", int'(wrap), 0);
      @(negedge clk);
      rst  = 1'b0;
      mcnt = 0;
      step(0, 0, 1, 1);

      // Random mix of load/en/up.
      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 7) == 0), int'($urandom_range(0, M - 1)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end
      step(0, 0, 0, 0);

`ifdef GRAY_CNT_CHECK_EN
      // Corrupt bin mid-count so the next step jumps two gray bits.
      do_reset();
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      @(negedge clk);
      en = 1'b1;
      up = 1'b1;
      force dut.bin_reg = 3;
      @(posedge clk);
      #1;
      release dut.bin_reg;
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("err_set", int'(err), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("err_sticky", int'(err), 1);
      do_reset();
`endif

      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
